// File: rtl/uart_pkg.sv
// Shared types and constants for the result UART transmitter.
// Optional feature macro: RESULT_TX_PARITY_EN (adds an even-parity bit per byte).
package uart_pkg;

    localparam logic        START_BIT     = 1'b0;
    localparam logic        STOP_BIT      = 1'b1;
    localparam int unsigned BITS_PER_BYTE = 8;

`ifdef RESULT_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_t;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time generator: counts CLKS_PER_BIT cycles and flags the last cycle of each bit.
// Optional feature macro: RESULT_TX_PARITY_EN (not used in this file).
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_bit_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Bit-time counter; clear aligns bit boundaries to the accept edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_bit_tick = i_en && (r_cnt == LAST_CNT);

endmodule

// File: rtl/result_uart_tx.sv
// Sends a DATA_W-bit result word as DATA_W/8 UART frames, MSB byte first, LSB bit first.
// Optional feature macro: RESULT_TX_PARITY_EN (11-bit frames with even parity).
module result_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] result_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              tx_o,
    output logic              busy_o
);

    localparam int unsigned NBYTES    = DATA_W / 8;
    localparam int unsigned BYTE_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(BITS_PER_BYTE - 1);

    tx_state_t         r_state;
    logic [DATA_W-1:0] r_word;
    logic [2:0]        r_bit_idx;
    logic [BYTE_W-1:0] r_byte_idx;
    logic              r_tx;
    logic              r_ready;
    logic              r_busy;

    logic              w_accept;
    logic              w_bit_tick;
    logic [7:0]        w_cur_byte;

    assign w_accept   = valid_i && r_ready;
    // The word register is shifted left per byte, so the byte in flight is always on top.
    assign w_cur_byte = r_word[DATA_W-1 -: 8];

`ifdef RESULT_TX_PARITY_EN
    logic w_parity;
    assign w_parity = ^w_cur_byte;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_accept),
        .i_en      (r_busy),
        .o_bit_tick(w_bit_tick)
    );

    // Transmit FSM with registered line and handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_word     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_tx       <= STOP_BIT;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_word     <= result_i;
                        r_state    <= StStart;
                        r_tx       <= START_BIT;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                        r_bit_idx  <= '0;
                        r_byte_idx <= '0;
                    end
                end
                StStart: begin
                    if (w_bit_tick) begin
                        r_state   <= StData;
                        r_tx      <= w_cur_byte[0];
                        r_bit_idx <= '0;
                    end
                end
                StData: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == LAST_BIT) begin
                            r_bit_idx <= '0;
`ifdef RESULT_TX_PARITY_EN
                            r_state   <= StParity;
                            r_tx      <= w_parity;
`else
                            r_state   <= StStop;
                            r_tx      <= STOP_BIT;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= w_cur_byte[r_bit_idx + 3'd1];
                        end
                    end
                end
`ifdef RESULT_TX_PARITY_EN
                StParity: begin
                    if (w_bit_tick) begin
                        r_state <= StStop;
                        r_tx    <= STOP_BIT;
                    end
                end
`endif
                StStop: begin
                    if (w_bit_tick) begin
                        if (r_byte_idx == LAST_BYTE) begin
                            r_state    <= StIdle;
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_byte_idx <= '0;
                        end else begin
                            r_state    <= StStart;
                            r_tx       <= START_BIT;
                            r_byte_idx <= r_byte_idx + BYTE_W'(1);
                            r_word     <= r_word << 8;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign tx_o    = r_tx;
    assign ready_o = r_ready;
    assign busy_o  = r_busy;

endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx with CLKS_PER_BIT=4, DATA_W=32.
// Optional feature macro: RESULT_TX_PARITY_EN (bench expects 11-bit frames when defined).
module tb_result_uart_tx;

    localparam int CPB = 4;
`ifdef RESULT_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int WORD_CYC = 4 * FRAME * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] result = 32'h0;
    logic        ready;
    logic        tx;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] word;
        int          ready_low;
    } vec_t;

    vec_t vecs[6];

    result_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .result_i(result),
        .valid_i (valid),
        .ready_o (ready),
        .tx_o    (tx),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    endtask

    // Line monitor: decodes frames mid-bit and compares against the scoreboard.
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [10:0] mon_bits;
    logic [7:0] mon_byte;
    always @(negedge clk) begin
        if (!rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if ((mon_cnt % CPB) == (CPB / 2)) begin
                mon_bits[mon_cnt / CPB] = tx;
                if ((mon_cnt / CPB) == FRAME - 1) begin
                    mon_active = 1'b0;
                    mon_byte   = mon_bits[8:1];
                    check("start bit", {31'b0, mon_bits[0]}, 32'd0);
                    check("stop bit", {31'b0, mon_bits[FRAME-1]}, 32'd1);
`ifdef RESULT_TX_PARITY_EN
                    check("parity bit", {31'b0, mon_bits[9]}, {31'b0, ^mon_byte});
`endif
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected byte: got %0h want none", mon_byte);
                    end else begin
                        check("byte", {24'b0, mon_byte}, {24'b0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("ready timeout", {31'b0, ready}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, output int low_cycles);
        wait_ready();
        @(negedge clk);
        valid  = 1'b1;
        result = w;
        @(posedge clk);
        #1;
        valid = 1'b0;
        push_word(w);
        check("start latency", {31'b0, tx}, 32'd0);
        check("busy after accept", {31'b0, busy}, 32'd1);
        low_cycles = 0;
        while (!ready && low_cycles < 2000) begin
            @(negedge clk);
            if (!ready) low_cycles++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int trans;
        int n;
        logic prev;
        logic rdy;

        vecs[0] = '{32'hA53C01FF, WORD_CYC};
        vecs[1] = '{32'h00000000, WORD_CYC};
        vecs[2] = '{32'hFFFFFFFF, WORD_CYC};
        vecs[3] = '{32'h03000000, WORD_CYC};
        vecs[4] = '{32'h80000155, WORD_CYC};
        vecs[5] = '{32'h7E81C3DB, WORD_CYC};

        // Reset: hold 3 cycles, release, then watch an idle line.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset tx", {31'b0, tx}, 32'd1);
        check("reset ready", {31'b0, ready}, 32'd1);
        check("reset busy", {31'b0, busy}, 32'd0);
        trans = 0;
        prev  = tx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== prev) trans++;
            prev = tx;
        end
        check("idle transitions", trans, 32'd0);

        // Table-driven words: bytes checked by the monitor, duration checked here.
        for (int i = 0; i < 6; i++) begin
            send_word(vecs[i].word, low);
            check("ready low cycles", low, vecs[i].ready_low);
        end

        // Back-to-back with valid held high.
        wait_ready();
        @(negedge clk);
        valid  = 1'b1;
        result = 32'h00000001;
        @(posedge clk);
        #1;
        push_word(32'h00000001);
        result = 32'hFFFFFFFF;
        n = 0;
        do begin
            @(negedge clk);
            rdy = ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 2000);
        push_word(32'hFFFFFFFF);
        #1;
        valid = 1'b0;
        check("b2b accept spacing", n, WORD_CYC + 1);
        check("b2b start bit", {31'b0, tx}, 32'd0);
        wait_ready();

        // Valid pulse while busy is ignored.
        @(negedge clk);
        valid  = 1'b1;
        result = 32'hCAFEBABE;
        @(posedge clk);
        #1;
        valid = 1'b0;
        push_word(32'hCAFEBABE);
        repeat (50) @(negedge clk);
        valid  = 1'b1;
        result = 32'h12345678;
        @(negedge clk);
        check("ready while busy", {31'b0, ready}, 32'd0);
        valid = 1'b0;
        wait_ready();
        repeat (20) @(negedge clk);
        check("no queued word", {31'b0, busy}, 32'd0);
        check("busy word drained", exp_q.size(), 32'd0);

        // Reset in the middle of the third byte's data bits.
        @(negedge clk);
        valid  = 1'b1;
        result = 32'h11223344;
        @(posedge clk);
        #1;
        valid = 1'b0;
        push_word(32'h11223344);
        repeat (96) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset tx", {31'b0, tx}, 32'd1);
        check("midreset ready", {31'b0, ready}, 32'd1);
        check("midreset busy", {31'b0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b1;
        send_word(32'h000000AA, low);
        check("post-reset word cycles", low, WORD_CYC);

        repeat (10) @(negedge clk);
        check("scoreboard empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
